// File: rtl/pipe_mips20_pkg.sv
// Shared opcodes, instruction-type enum and field positions for the pipe_mips20 core.
// MIPS_MUL_EN controls whether opcode 000101 decodes as a register-register multiply.
package pipe_mips20_pkg;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_SGT   = 6'b000111;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  localparam int OP_HI = 31;
  localparam int OP_LO = 26;
  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;
  localparam int RD_HI = 15;
  localparam int RD_LO = 11;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  localparam logic [31:0] NOP_IR = 32'h0000_0000;

  typedef enum logic [2:0] {
    NOP    = 3'd0,
    RR_ALU = 3'd1,
    RM_ALU = 3'd2,
    LOAD   = 3'd3,
    STORE  = 3'd4,
    BRANCH = 3'd5,
    HALT   = 3'd6
  } itype_e;

  function automatic itype_e decode_type(input logic [5:0] op);
    itype_e t;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_SGT: t = RR_ALU;
`ifdef MIPS_MUL_EN
      OP_MUL:                                        t = RR_ALU;
`endif
      OP_ADDI, OP_SUBI, OP_SLTI:                     t = RM_ALU;
      OP_LW:                                         t = LOAD;
      OP_SW:                                         t = STORE;
      OP_BNEQZ, OP_BEQZ:                             t = BRANCH;
      OP_HLT:                                        t = HALT;
      default:                                       t = NOP;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/pipe_mips20_alu.sv
// Combinational integer ALU for the EX stage; zero latency, no flow control.
// The multiplier exists only when MIPS_MUL_EN is defined; otherwise 000101 yields 0.
module pipe_mips20_alu
  import pipe_mips20_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result
);

  always_comb begin
    result = '0;
    case (op)
      OP_ADD: result = a + b;
      OP_SUB: result = a - b;
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_SLT: result = {31'd0, $signed(a) < $signed(b)};
      OP_SGT: result = {31'd0, $signed(a) > $signed(b)};
`ifdef MIPS_MUL_EN
      OP_MUL: result = a * b;
`endif
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/pipe_mips20.sv
// 5-stage in-order MIPS-style core (IF/ID/EX/MEM/WB), no interlocks; software pads hazards with NOPs.
// A taken branch resolves in MEM and squashes the three younger instructions; MIPS_MUL_EN enables MUL.
module pipe_mips20
  import pipe_mips20_pkg::*;
#(
  parameter int          MEM_DEPTH = 1024,
  parameter logic [31:0] RESET_PC  = 32'd0
) (
  input  logic        clk1,
  input  logic        rst_n,
  output logic [31:0] pc_out,
  output logic [31:0] alu_result,
  output logic        halted_out,
  output logic [31:0] debug_operand1,
  output logic [31:0] debug_operand2
);

  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  logic [31:0] Mem [0:MEM_DEPTH-1];
  logic [31:0] Reg [0:31];

  logic [31:0] pc_q, pc_d;
  logic        halted_q, halted_d;
  logic [31:0] ifid_ir_q, ifid_ir_d, ifid_npc_q, ifid_npc_d;
  logic [5:0]  idex_op_q, idex_op_d;
  itype_e      idex_type_q, idex_type_d;
  logic [4:0]  idex_dest_q, idex_dest_d;
  logic [31:0] idex_npc_q, idex_npc_d, idex_a_q, idex_a_d;
  logic [31:0] idex_b_q, idex_b_d, idex_imm_q, idex_imm_d;
  itype_e      exmem_type_q, exmem_type_d;
  logic [4:0]  exmem_dest_q, exmem_dest_d;
  logic [31:0] exmem_alu_q, exmem_alu_d, exmem_b_q, exmem_b_d;
  logic        exmem_cond_q, exmem_cond_d;
  itype_e      memwb_type_q, memwb_type_d;
  logic [4:0]  memwb_dest_q, memwb_dest_d;
  logic [31:0] memwb_alu_q, memwb_alu_d, memwb_lmd_q, memwb_lmd_d;

  logic [AW-1:0] fetch_idx, mem_idx;
  logic          mem_we, reg_we;
  logic [4:0]    reg_waddr;
  logic [31:0]   reg_wdata;

  logic [5:0]  id_op;
  logic [4:0]  id_rs, id_rt, id_rd, id_dest;
  itype_e      id_type;
  logic [5:0]  ex_alu_op;
  logic [31:0] ex_alu_a, ex_alu_b, ex_alu_y;
  logic        ex_taken;

  assign fetch_idx = AW'(pc_q % 32'(MEM_DEPTH));
  assign mem_idx   = AW'(exmem_alu_q % 32'(MEM_DEPTH));

  assign id_op   = ifid_ir_q[OP_HI:OP_LO];
  assign id_rs   = ifid_ir_q[RS_HI:RS_LO];
  assign id_rt   = ifid_ir_q[RT_HI:RT_LO];
  assign id_rd   = ifid_ir_q[RD_HI:RD_LO];
  assign id_type = decode_type(id_op);

  always_comb begin
    id_dest = 5'd0;
    case (id_type)
      RR_ALU:       id_dest = id_rd;
      RM_ALU, LOAD: id_dest = id_rt;
      default:      id_dest = 5'd0;
    endcase
  end

  always_comb begin
    ex_alu_op = OP_ADD;
    if (idex_type_q == RR_ALU) begin
      ex_alu_op = idex_op_q;
    end else if (idex_type_q == RM_ALU) begin
      case (idex_op_q)
        OP_SUBI: ex_alu_op = OP_SUB;
        OP_SLTI: ex_alu_op = OP_SLT;
        default: ex_alu_op = OP_ADD;
      endcase
    end
  end

  // Branches reuse the adder to form NPC + imm; everything else adds from rs.
  assign ex_alu_a = (idex_type_q == BRANCH) ? idex_npc_q : idex_a_q;
  assign ex_alu_b = (idex_type_q == RR_ALU) ? idex_b_q : idex_imm_q;
  assign ex_taken = (idex_type_q == BRANCH) &&
                    ((idex_op_q == OP_BEQZ) ? (idex_a_q == 32'd0) : (idex_a_q != 32'd0));

  pipe_mips20_alu u_alu (
    .op     (ex_alu_op),
    .a      (ex_alu_a),
    .b      (ex_alu_b),
    .result (ex_alu_y)
  );

  always_comb begin
    pc_d = pc_q;               halted_d = halted_q;
    ifid_ir_d = ifid_ir_q;     ifid_npc_d = ifid_npc_q;
    idex_op_d = idex_op_q;     idex_type_d = idex_type_q;   idex_dest_d = idex_dest_q;
    idex_npc_d = idex_npc_q;   idex_a_d = idex_a_q;
    idex_b_d = idex_b_q;       idex_imm_d = idex_imm_q;
    exmem_type_d = exmem_type_q; exmem_dest_d = exmem_dest_q;
    exmem_alu_d = exmem_alu_q;   exmem_b_d = exmem_b_q;     exmem_cond_d = exmem_cond_q;
    memwb_type_d = memwb_type_q; memwb_dest_d = memwb_dest_q;
    memwb_alu_d = memwb_alu_q;   memwb_lmd_d = memwb_lmd_q;
    mem_we = 1'b0;  reg_we = 1'b0;  reg_waddr = 5'd0;  reg_wdata = 32'd0;

    if (!halted_q) begin
      // Younger stages advance normally unless the branch in EX/MEM redirects fetch.
      if (exmem_cond_q) begin
        pc_d = exmem_alu_q;
        ifid_ir_d = NOP_IR;    ifid_npc_d = 32'd0;
        idex_op_d = 6'd0;      idex_type_d = NOP;  idex_dest_d = 5'd0;
        idex_npc_d = 32'd0;    idex_a_d = 32'd0;   idex_b_d = 32'd0;  idex_imm_d = 32'd0;
        exmem_type_d = NOP;    exmem_dest_d = 5'd0;
        exmem_alu_d = 32'd0;   exmem_b_d = 32'd0;  exmem_cond_d = 1'b0;
      end else begin
        pc_d = pc_q + 32'd1;
        ifid_ir_d  = Mem[fetch_idx];
        ifid_npc_d = pc_q + 32'd1;
        idex_op_d   = id_op;
        idex_type_d = id_type;
        idex_dest_d = id_dest;
        idex_npc_d  = ifid_npc_q;
        idex_a_d    = Reg[id_rs];
        idex_b_d    = Reg[id_rt];
        idex_imm_d  = {{16{ifid_ir_q[IMM_HI]}}, ifid_ir_q[IMM_HI:IMM_LO]};
        exmem_type_d = idex_type_q;
        exmem_dest_d = idex_dest_q;
        exmem_alu_d  = ex_alu_y;
        exmem_b_d    = idex_b_q;
        exmem_cond_d = ex_taken;
      end

      memwb_type_d = exmem_type_q;
      memwb_dest_d = exmem_dest_q;
      memwb_alu_d  = exmem_alu_q;
      memwb_lmd_d  = Mem[mem_idx];
      mem_we       = (exmem_type_q == STORE);

      case (memwb_type_q)
        RR_ALU, RM_ALU: begin reg_waddr = memwb_dest_q; reg_wdata = memwb_alu_q; end
        LOAD:           begin reg_waddr = memwb_dest_q; reg_wdata = memwb_lmd_q; end
        HALT:           halted_d = 1'b1;
        default:        reg_waddr = 5'd0;
      endcase
      reg_we = (reg_waddr != 5'd0);
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;      halted_q <= 1'b0;
      ifid_ir_q <= NOP_IR;   ifid_npc_q <= '0;
      idex_op_q <= '0;       idex_type_q <= NOP;   idex_dest_q <= '0;
      idex_npc_q <= '0;      idex_a_q <= '0;       idex_b_q <= '0;  idex_imm_q <= '0;
      exmem_type_q <= NOP;   exmem_dest_q <= '0;
      exmem_alu_q <= '0;     exmem_b_q <= '0;      exmem_cond_q <= 1'b0;
      memwb_type_q <= NOP;   memwb_dest_q <= '0;
      memwb_alu_q <= '0;     memwb_lmd_q <= '0;
    end else begin
      pc_q <= pc_d;          halted_q <= halted_d;
      ifid_ir_q <= ifid_ir_d;       ifid_npc_q <= ifid_npc_d;
      idex_op_q <= idex_op_d;       idex_type_q <= idex_type_d;   idex_dest_q <= idex_dest_d;
      idex_npc_q <= idex_npc_d;     idex_a_q <= idex_a_d;
      idex_b_q <= idex_b_d;         idex_imm_q <= idex_imm_d;
      exmem_type_q <= exmem_type_d; exmem_dest_q <= exmem_dest_d;
      exmem_alu_q <= exmem_alu_d;   exmem_b_q <= exmem_b_d;       exmem_cond_q <= exmem_cond_d;
      memwb_type_q <= memwb_type_d; memwb_dest_q <= memwb_dest_d;
      memwb_alu_q <= memwb_alu_d;   memwb_lmd_q <= memwb_lmd_d;
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) Reg[i] <= '0;
    end else if (reg_we) begin
      Reg[reg_waddr] <= reg_wdata;
    end
  end

  always_ff @(posedge clk1) begin
    if (mem_we) Mem[mem_idx] <= exmem_b_q;
  end

  assign pc_out         = pc_q;
  assign alu_result     = exmem_alu_q;
  assign halted_out     = halted_q;
  assign debug_operand1 = idex_a_q;
  assign debug_operand2 = ex_alu_b;

endmodule

// File: tb/tb_pipe_mips20.sv
// Directed programs for pipe_mips20; expected register/memory/PC state is queued per program
// and a monitor compares it when the core reports halted.
module tb_pipe_mips20;

  localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, AND_ = 6'b000010, OR_ = 6'b000011;
  localparam logic [5:0] SLT = 6'b000100, MUL = 6'b000101, SGT = 6'b000111;
  localparam logic [5:0] LW = 6'b001000, SW = 6'b001001, ADDI = 6'b001010, SUBI = 6'b001011;
  localparam logic [5:0] SLTI = 6'b001100, BNEQZ = 6'b001101, HLT = 6'b111111;
  localparam int K_REG = 0, K_MEM = 1, K_PC = 2, K_HLT = 3;

  typedef struct {
    int          kind;
    int          idx;
    logic [31:0] val;
  } exp_t;

  logic        clk1, rst_n, halted_out;
  logic [31:0] pc_out, alu_result, debug_operand1, debug_operand2;

  exp_t        exp_q[$];
  logic [31:0] prog[$];
  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;

  pipe_mips20 dut (
    .clk1           (clk1),
    .rst_n          (rst_n),
    .pc_out         (pc_out),
    .alu_result     (alu_result),
    .halted_out     (halted_out),
    .debug_operand1 (debug_operand1),
    .debug_operand2 (debug_operand2)
  );

  initial begin
    clk1 = 1'b0;
    forever #5 clk1 = ~clk1;
  end

  function automatic logic [31:0] rr(input logic [5:0] op, input int rd, input int rs, input int rt);
    return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
  endfunction

  function automatic logic [31:0] ri(input logic [5:0] op, input int rt, input int rs, input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  task automatic expect_val(input int kind, input int idx, input logic [31:0] val);
    exp_t e;
    e.kind = kind;
    e.idx  = idx;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) prog.push_back(32'h0);
  endtask

  task automatic load_prog();
    for (int i = 0; i < 1024; i++) dut.Mem[i] = 32'h0;
    for (int i = 0; i < prog.size(); i++) dut.Mem[i] = prog[i];
  endtask

  task automatic do_reset();
    @(negedge clk1);
    rst_n = 1'b0;
    #1;
  endtask

  task automatic run_to_halt(input int budget);
    int start;
    int n;
    start = done_cnt;
    n = 0;
    @(negedge clk1);
    rst_n = 1'b1;
    while (done_cnt == start && n < budget) begin
      @(negedge clk1);
      n++;
    end
    if (done_cnt == start) begin
      checks++;
      errors++;
      $display("FAIL timeout: no halt within %0d cycles (pending %0d)", budget, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Compares the queued end-of-program state once halted_out is first seen.
  initial begin : monitor
    exp_t        e;
    logic [31:0] got;
    bit          seen;
    seen = 1'b0;
    forever begin
      @(negedge clk1);
      if (!rst_n) begin
        seen = 1'b0;
      end else if (halted_out && !seen) begin
        seen = 1'b1;
        while (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          case (e.kind)
            K_REG:   got = dut.Reg[e.idx];
            K_MEM:   got = dut.Mem[e.idx];
            K_PC:    got = pc_out;
            default: got = {31'd0, halted_out};
          endcase
          check($sformatf("%s%0d", (e.kind == K_REG) ? "reg" : (e.kind == K_MEM) ? "mem" :
                          (e.kind == K_PC) ? "pc" : "halted", e.idx), got, e.val);
        end
        done_cnt++;
      end
    end
  end

  task automatic build_prog_a();
    prog.delete();
    prog.push_back(ri(ADDI, 1, 0, 50));  nops(3);
    prog.push_back(ri(ADDI, 2, 0, 25));  nops(3);
    prog.push_back(rr(SGT, 3, 1, 2));    nops(3);
    prog.push_back(rr(SGT, 4, 2, 1));
    prog.push_back(ri(ADDI, 0, 0, 9));   nops(3);
    prog.push_back({HLT, 26'd0});
    prog.push_back(ri(ADDI, 6, 0, 77));
  endtask

  task automatic expect_prog_a();
    expect_val(K_REG, 1, 32'd50);
    expect_val(K_REG, 2, 32'd25);
    expect_val(K_REG, 3, 32'd1);
    expect_val(K_REG, 4, 32'd0);
    expect_val(K_REG, 0, 32'd0);
    expect_val(K_REG, 6, 32'd0);
    expect_val(K_PC, 0, 32'd22);
    expect_val(K_HLT, 0, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    build_prog_a();
    load_prog();
    repeat (2) @(negedge clk1);
    check("reset_pc", pc_out, 32'd0);
    check("reset_halted", {31'd0, halted_out}, 32'd0);
    check("reset_alu", alu_result, 32'd0);
    check("reset_op1", debug_operand1, 32'd0);
    check("reset_op2", debug_operand2, 32'd0);

    // Program A: SGT, R0 write suppression, nothing retires after HLT.
    expect_prog_a();
    run_to_halt(200);
    repeat (20) @(negedge clk1);
    check("post_halt_pc", pc_out, 32'd22);
    check("post_halt_r6", dut.Reg[6], 32'd0);
    check("post_halt_halted", {31'd0, halted_out}, 32'd1);

    // Program B: signed compares and the remaining ALU ops on a negative operand.
    do_reset();
    check("rst_halted", {31'd0, halted_out}, 32'd0);
    check("rst_r1", dut.Reg[1], 32'd0);
    prog.delete();
    prog.push_back(ri(ADDI, 1, 0, -5));
    prog.push_back(ri(ADDI, 2, 0, 3));   nops(3);
    prog.push_back(rr(SLT, 3, 1, 2));
    prog.push_back(rr(SGT, 4, 1, 2));
    prog.push_back(ri(SLTI, 5, 1, -4));
    prog.push_back(rr(SUB, 6, 2, 1));
    prog.push_back(rr(AND_, 7, 1, 2));
    prog.push_back(rr(OR_, 8, 1, 2));
    prog.push_back(rr(ADD, 9, 1, 2));
    prog.push_back(ri(SUBI, 10, 2, 5));
    prog.push_back(rr(MUL, 11, 1, 2));   nops(3);
    prog.push_back({HLT, 26'd0});
    load_prog();
    expect_val(K_REG, 1, 32'hFFFF_FFFB);
    expect_val(K_REG, 3, 32'd1);
    expect_val(K_REG, 4, 32'd0);
    expect_val(K_REG, 5, 32'd1);
    expect_val(K_REG, 6, 32'd8);
    expect_val(K_REG, 7, 32'd3);
    expect_val(K_REG, 8, 32'hFFFF_FFFB);
    expect_val(K_REG, 9, 32'hFFFF_FFFE);
    expect_val(K_REG, 10, 32'hFFFF_FFFE);
`ifdef MIPS_MUL_EN
    expect_val(K_REG, 11, 32'hFFFF_FFF1);
`else
    expect_val(K_REG, 11, 32'd0);
`endif
    expect_val(K_PC, 0, 32'd22);
    run_to_halt(200);

    // Program C: store then load, plus a load whose address wraps to the last word.
    do_reset();
    prog.delete();
    prog.push_back(ri(ADDI, 1, 0, 7));
    prog.push_back(ri(ADDI, 2, 0, 100)); nops(3);
    prog.push_back(ri(SW, 1, 2, 100));
    prog.push_back(ri(LW, 5, 2, 100));
    prog.push_back(ri(LW, 7, 0, -1));    nops(3);
    prog.push_back({HLT, 26'd0});
    load_prog();
    dut.Mem[1023] = 32'hDEAD_BEEF;
    expect_val(K_MEM, 200, 32'd7);
    expect_val(K_REG, 5, 32'd7);
    expect_val(K_REG, 7, 32'hDEAD_BEEF);
    expect_val(K_PC, 0, 32'd16);
    run_to_halt(200);

    // Program D: BNEQZ loop; R2 counts body passes, R3 counts fall-through past the branch.
    do_reset();
    prog.delete();
    prog.push_back(ri(ADDI, 1, 0, 3));   nops(3);
    prog.push_back(ri(ADDI, 2, 2, 1));
    prog.push_back(ri(SUBI, 1, 1, 1));   nops(3);
    prog.push_back(ri(BNEQZ, 0, 1, -6));
    nops(1);
    prog.push_back(ri(ADDI, 3, 3, 1));   nops(3);
    prog.push_back({HLT, 26'd0});
    load_prog();
    expect_val(K_REG, 1, 32'd0);
    expect_val(K_REG, 2, 32'd3);
    expect_val(K_REG, 3, 32'd1);
    expect_val(K_PC, 0, 32'd20);
    run_to_halt(400);

    // Mid-program reset on program A, then a full rerun.
    do_reset();
    build_prog_a();
    load_prog();
    @(negedge clk1);
    rst_n = 1'b1;
    repeat (10) @(negedge clk1);
    check("mid_op1", debug_operand1, 32'd50);
    check("mid_op2", debug_operand2, 32'd25);
    @(negedge clk1);
    check("mid_pc", pc_out, 32'd11);
    check("mid_alu", alu_result, 32'd1);
    check("mid_r1", dut.Reg[1], 32'd50);
    rst_n = 1'b0;
    #1;
    check("mid_rst_pc", pc_out, 32'd0);
    check("mid_rst_alu", alu_result, 32'd0);
    check("mid_rst_halted", {31'd0, halted_out}, 32'd0);
    check("mid_rst_r1", dut.Reg[1], 32'd0);
    check("mid_rst_r2", dut.Reg[2], 32'd0);
    expect_prog_a();
    run_to_halt(200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
